dispatch_in_order: RTL

Round-robin dispatcher that takes a single serial stream of operands and hands them one by one to an array of n non-pipelined, variable-latency computational blocks: lane 0, lane 1, …, lane n-1, then lane 0 again.
It is the upstream counterpart of the in-order result collector. Because it dispatches in strict rotation, the collector can reassemble results in the original order.
It tracks per-lane busy state from the blocks' completion pulses and applies backpressure upstream when the next lane in rotation is still busy.

---
 rtl/dispatch_in_order.sv | 73 +++++++
 1 files changed

// File: rtl/dispatch_in_order.sv
// Round-robin dispatcher: hands a serial operand stream to n non-pipelined lanes in strict
// rotation, stalling upstream whenever the next lane in turn is still busy.
module dispatch_in_order #(
  parameter int unsigned width     = 16,
  parameter int unsigned n_outputs = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 up_vld,
  output logic                                 up_rdy,
  input  logic [width-1:0]                     up_data,
  output logic [n_outputs-1:0]                 down_vlds,
  output logic [n_outputs-1:0][width-1:0]      down_data,
  input  logic [n_outputs-1:0]                 done_vlds,
  output logic [$clog2(n_outputs+1)-1:0]       in_flight,
  output logic                                 err
);

  localparam int unsigned PtrW = (n_outputs > 1) ? $clog2(n_outputs) : 1;
  localparam int unsigned CntW = $clog2(n_outputs + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(n_outputs - 1);

  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [n_outputs-1:0] busy_q, busy_d;
  logic [CntW-1:0]      cnt_d;
  logic                 accept;

  // Ready depends only on registered state, never on done_vlds or up_vld.
  always_comb begin
    up_rdy = ~busy_q[ptr_q];
    accept = up_vld & up_rdy;

    busy_d = busy_q & ~done_vlds;
    if (accept) begin
      busy_d[ptr_q] = 1'b1;
    end

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
    end

    cnt_d = '0;
    for (int i = 0; i < int'(n_outputs); i++) begin
      cnt_d = cnt_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      busy_q    <= '0;
      down_vlds <= '0;
      down_data <= '0;
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      down_vlds <= '0;
      if (accept) begin
        down_vlds[ptr_q] <= 1'b1;
        down_data[ptr_q] <= up_data;
      end
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      in_flight <= cnt_d;
      // A completion on an idle lane means the blocks and dispatcher disagree.
      if (|(done_vlds & ~busy_q)) begin
        err <= 1'b1;
      end
    end
  end

endmodule
